ecp5pll_phase_ctrl: RTL and testbench

ECP5PLL_PHASE_CTRL -- requirements
Module: ecp5pll_phase_ctrl

---
 rtl/ecp5pll_phase_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_ecp5pll_phase_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecp5pll_phase_ctrl.sv
// ecp5pll_phase_ctrl
// Sequences the ECP5 PLL dynamic phase-shift pins (phasesel, phasedir,
// phasestep, phaseloadreg) for one command at a time, then waits for the
// PLL to re-lock. It signals done on success, or raises a sticky err flag
// if lock does not return within LOCK_TO_CYC cycles.
// All outputs come straight from flops. Each state's length is measured by
// a single cycle counter that restarts whenever the state changes.
module ecp5pll_phase_ctrl #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STEP_HI_CYC = 4,
  parameter int unsigned STEP_LO_CYC = 4,
  parameter int unsigned LOCK_TO_CYC = 65535
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sel,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_steps,
  input  logic       cmd_load,
  input  logic       pll_locked,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // The counter is wide enough for the largest lock timeout (2^20-1).
  localparam int unsigned CNT_W = 20;

  // Counter values on the last cycle of each timed state.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LAST    = CNT_W'(STEP_HI_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LAST    = CNT_W'(STEP_LO_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_STEP_HI   = 3'd2,
    ST_STEP_LO   = 3'd3,
    ST_LOAD      = 3'd4,
    ST_WAIT_LOCK = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       steps_q, steps_d;
  logic             load_q, load_d;
  logic [1:0]       sel_q, sel_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             ldreg_q, ldreg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             sync1_q;
  logic             lk_q;
  logic             accept;

  assign accept = cmd_valid & ready_q;

  // Bring the asynchronous PLL lock into the clk_i domain (two flops).
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_q    <= sync1_q;
    end
  end

  // Next-state logic, command capture, the step countdown and done/err.
  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    load_d  = load_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          steps_d = cmd_steps;
          load_d  = cmd_load;
          sel_d   = cmd_sel;
          dir_d   = cmd_dir;
          err_d   = 1'b0;
          if ((cmd_steps == 8'd0) && !cmd_load) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            state_d = ST_SETUP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          if (steps_q != 8'd0) begin
            state_d = ST_STEP_HI;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_STEP_HI: begin
        if (cnt_q == HI_LAST) begin
          state_d = ST_STEP_LO;
          // Decrement only when a step is actually owed, so 0 cannot wrap to 255.
          if (steps_q != 8'd0) begin
            steps_d = steps_q - 8'd1;
          end else begin
            steps_d = steps_q;
          end
        end else begin
          state_d = ST_STEP_HI;
        end
      end
      ST_STEP_LO: begin
        if (cnt_q == LO_LAST) begin
          if (steps_q != 8'd0) begin
            state_d = ST_STEP_HI;
          end else if (load_q) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end else begin
          state_d = ST_STEP_LO;
        end
      end
      ST_LOAD: begin
        if (cnt_q == HI_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock is only consulted here; stepping is expected to disturb it.
        if (lk_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cycle counter: restarts on every state change, sits at 0 in IDLE, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output levels follow the next state, so each registered output lines up with state_q.
  always_comb begin
    step_d  = (state_d == ST_STEP_HI);
    ldreg_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // Register the FSM state, counters, captured command and all outputs.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      steps_q <= 8'd0;
      load_q  <= 1'b0;
      sel_q   <= 2'd0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      ldreg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      load_q  <= load_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      ldreg_q <= ldreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = ldreg_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Testbench for ecp5pll_phase_ctrl. A reference model builds the expected
// per-cycle phasestep/phaseloadreg timeline for each command from the
// timing rules (setup, high, low, load, lock wait). The bench then compares
// the DUT against that timeline on every cycle.
module tb_ecp5pll_phase_ctrl;

  localparam int S  = 2;
  localparam int H  = 4;
  localparam int L  = 4;
  localparam int TO = 100;

  logic       clk_i = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_sel = 2'd0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_steps = 8'd0;
  logic       cmd_load = 1'b0;
  logic       pll_locked = 1'b0;
  logic       cmd_ready;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       busy;
  logic       done;
  logic       err;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] exp_sel = 2'd0;
  logic       exp_dir = 1'b0;
  logic       exp_err = 1'b0;

  ecp5pll_phase_ctrl #(
    .SETUP_CYC  (S),
    .STEP_HI_CYC(H),
    .STEP_LO_CYC(L),
    .LOCK_TO_CYC(TO)
  ) dut (
    .clk_i       (clk_i),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_sel     (cmd_sel),
    .cmd_dir     (cmd_dir),
    .cmd_steps   (cmd_steps),
    .cmd_load    (cmd_load),
    .pll_locked  (pll_locked),
    .phasesel    (phasesel),
    .phasedir    (phasedir),
    .phasestep   (phasestep),
    .phaseloadreg(phaseloadreg),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ready"}, cmd_ready, 1'b0);
    chkn({tag, "_sel"}, 32'(phasesel), 32'd0);
    chk1({tag, "_dir"}, phasedir, 1'b0);
    chk1({tag, "_step"}, phasestep, 1'b0);
    chk1({tag, "_ldreg"}, phaseloadreg, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  // One full command. lockok: PLL locked when lock is awaited (else timeout).
  // glitch: drop pll_locked during the pulse phase. junk: random cmd traffic while busy.
  task automatic run_cmd(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                         input logic load, input logic lockok, input logic glitch,
                         input logic junk);
    logic exp_step[$];
    logic exp_ld[$];
    int   n_pre;
    int   total;
    int   rises;
    int   lrises;
    logic prev_s;
    logic prev_l;
    exp_step = {};
    exp_ld   = {};
    if ((steps != 8'd0) || load) begin
      repeat (S) begin exp_step.push_back(1'b0); exp_ld.push_back(1'b0); end
      for (int i = 0; i < int'(steps); i++) begin
        repeat (H) begin exp_step.push_back(1'b1); exp_ld.push_back(1'b0); end
        repeat (L) begin exp_step.push_back(1'b0); exp_ld.push_back(1'b0); end
      end
      if (load) begin
        repeat (H) begin exp_step.push_back(1'b0); exp_ld.push_back(1'b1); end
      end
    end
    n_pre = exp_step.size();
    repeat (lockok ? 1 : TO) begin exp_step.push_back(1'b0); exp_ld.push_back(1'b0); end
    total = exp_step.size();

    pll_locked = lockok;
    cmd_valid  = 1'b0;
    repeat (3) tick();
    chk1("idle_ready", cmd_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_err", err, exp_err);

    cmd_sel   = sel;
    cmd_dir   = dir;
    cmd_steps = steps;
    cmd_load  = load;
    cmd_valid = 1'b1;
    tick();
    exp_sel = sel;
    exp_dir = dir;
    exp_err = 1'b0;
    rises  = 0;
    lrises = 0;
    prev_s = 1'b0;
    prev_l = 1'b0;
    for (int k = 1; k <= total; k++) begin
      chk1("run_step", phasestep, exp_step[k-1]);
      chk1("run_ldreg", phaseloadreg, exp_ld[k-1]);
      chk1("run_busy", busy, 1'b1);
      chk1("run_ready", cmd_ready, 1'b0);
      chk1("run_done", done, 1'b0);
      chk1("run_err", err, 1'b0);
      chkn("run_sel", 32'(phasesel), 32'(exp_sel));
      chk1("run_dir", phasedir, exp_dir);
      if (phasestep && !prev_s) rises++;
      if (phaseloadreg && !prev_l) lrises++;
      prev_s = phasestep;
      prev_l = phaseloadreg;
      if (junk) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_sel   = 2'($urandom_range(0, 3));
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_steps = 8'($urandom_range(0, 255));
        cmd_load  = 1'($urandom_range(0, 1));
      end else begin
        cmd_valid = 1'b0;
      end
      if (lockok) begin
        pll_locked = !(glitch && (k + 4 <= n_pre));
      end
      tick();
    end
    cmd_valid = 1'b0;
    exp_err = !lockok;
    chk1("end_done", done, lockok);
    chk1("end_err", err, exp_err);
    chk1("end_busy", busy, 1'b0);
    chk1("end_ready", cmd_ready, 1'b1);
    chk1("end_step", phasestep, 1'b0);
    chkn("end_sel", 32'(phasesel), 32'(exp_sel));
    chk1("end_dir", phasedir, exp_dir);
    chkn("step_pulses", 32'(rises), 32'(steps));
    chkn("load_pulses", 32'(lrises), 32'(load));
    tick();
    chk1("post_done", done, 1'b0);
    chk1("post_err", err, exp_err);
  endtask

  initial begin
    // Reset state
    tick();
    chk_reset_outputs("reset");
    tick();
    chk_reset_outputs("reset_hold");
    @(negedge clk_i);
    reset_n = 1'b1;
    tick();
    chk1("first_ready", cmd_ready, 1'b1);

    // Directed commands
    run_cmd(2'd2, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cmd(2'd1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_cmd(2'd3, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cmd(2'd1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cmd(2'd0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    run_cmd(2'd2, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset during the second STEP_HI of a 5-step command
    pll_locked = 1'b1;
    repeat (3) tick();
    cmd_sel   = 2'd3;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd5;
    cmd_load  = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (S + H + L) tick();
    chk1("rst_pre_step", phasestep, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) tick();
    chk_reset_outputs("midrst_hold");
    @(negedge clk_i);
    reset_n = 1'b1;
    exp_sel = 2'd0;
    exp_dir = 1'b0;
    exp_err = 1'b0;
    tick();
    chk1("midrst_ready", cmd_ready, 1'b1);
    run_cmd(2'd1, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    // Randomized commands
    for (int n = 0; n < 10; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
